uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Round-robin scheduler that shares one UART TX push port among NUM_REQ requesters. Each requester submits a 10-bit value. The scheduler captures it and pushes a 7-byte ASCII frame into the UART controller TX FIFO: tag, four decimal digits, CR, LF. The block sits between the measurement/sensor blocks and the UART controller, replacing per-block ad-hoc senders.

## Interface
- NUM_REQ, 4: number of requesters; legal range 2–8.
- DATA_W, 10: requester value width; fixed at 10 in this revision.
- One clock; reset is synchronous and active-low.
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous active-low reset; sampled on the clk rising edge while 0.
- req_valid  in  NUM_REQ  per-requester request; hold high with stable data until req_ready.
- req_data  in  NUM_REQ*DATA_W  packed values; requester i is bits [i*10+9 : i*10].
- req_ready  out  NUM_REQ  one-hot, one-cycle capture acknowledge.
- tx_full  in  1  UART controller TX FIFO full.
- tx_push  out  1  registered one-cycle push strobe to the TX FIFO.
- tx_push_data  out  8  registered byte, valid while tx_push=1.
- busy  out  1  high while a frame is in progress (states CAPTURE and SEND).
- grant_id  out  $clog2(NUM_REQ)  index of the current or last granted requester.
- frame_done  out  1  one-cycle pulse in the cycle after the 7th byte is pushed.

## Operation
- States:
  - IDLE: when any req_valid=1, select the winner round-robin, starting at (last_grant+1) mod NUM_REQ. Capture its req_data, set grant_id, go to CAPTURE.
  - CAPTURE: assert req_ready[grant_id] for this cycle only. Load the 7-byte frame buffer. Set byte_idx=0, go to SEND.
  - SEND: push one byte under the push rule below. After byte_idx=6 is pushed, update last_grant=grant_id, pulse frame_done, go to IDLE.
- Frame bytes, in order:
  - Byte 0: tag = 8'h41 + grant_id ('A', 'B', …).
  - Bytes 1–4: thousands, hundreds, tens and units digits, each +8'h30.
  - Byte 5: 8'h0D (CR).
  - Byte 6: 8'h0A (LF).
- Values 0–1023 are representable: 1023 gives "1023", 7 gives "0007". No saturation.
- Push rule: a push is issued on the next edge only if tx_full=0 and tx_push=0 in the current cycle. Consecutive pushes are therefore at least 2 cycles apart. This covers the one-cycle full-flag latency of the FIFO.
- tx_full=1 stalls SEND indefinitely; byte_idx and the frame buffer hold.
- A req_valid that drops before grant is treated as withdrawn, with no side effect. req_valid changes during CAPTURE and SEND are ignored.
- Requests arriving while busy wait; arbitration occurs only in IDLE.
- No combinational path from req_valid or tx_full to any output.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: req_ready=0, tx_push=0, tx_push_data=8'h00, busy=0, grant_id=0, frame_done=0.
  - Internal: last_grant=NUM_REQ-1, so requester 0 has priority first.
- Latency:
  - req_valid seen in IDLE at edge E → req_ready high in cycle E+1.
  - First tx_push in cycle E+2, if tx_full=0.
- Unstalled frame:
  - tx_push high in cycles E+2, E+4, …, E+14.
  - frame_done in cycle E+15; IDLE in cycle E+15.
  - A new grant is possible at edge E+15.
- Reset mid-frame aborts immediately: no further pushes. The remaining bytes of the partial frame are lost; the bytes already pushed stay in the FIFO.
- Simultaneous requests: exactly one grant per frame. Each requester holding valid is served within NUM_REQ frames.

## Structure
- Shared package holds:
  - state encoding for IDLE, CAPTURE, SEND;
  - FRAME_LEN=7;
  - ASCII constants: ASCII_ZERO=8'h30, ASCII_TAG_BASE=8'h41, ASCII_CR=8'h0D, ASCII_LF=8'h0A.
- One sub-module, bin10_to_ascii4: combinational 10-bit to four ASCII digits using div/mod by 10, 100 and 1000. It is instantiated once on the captured value.
- Round-robin pick, frame buffer and FSM stay in uart_tx_scheduler.

## Test plan
- Single request: req_valid[2]=1, value 345, tx_full=0 → req_ready[2] pulse at E+1; bytes 43 30 33 34 35 0D 0A at E+2…E+14, 2-cycle spacing; frame_done at E+15.
- Edge values: requester 0 sends 0, then 1023 → frames "A0000\r\n" and "A1023\r\n".
- All four requesters held valid from reset → tags in order A, B, C, D, A; each req_ready is one-hot, one cycle.
- Backpressure: tx_full=1 for 20 cycles after byte 2 → no tx_push during the stall; resumes with byte 3 two cycles after tx_full falls (tx_full=0 sampled, then registered push); no byte lost or duplicated.
- Withdrawal and mid-frame events: req_valid[1] dropped while busy serving requester 0 → requester 1 is never granted. rst=0 at byte 3 → all outputs at reset values next cycle; after release, requester 0 wins first.

Source files
------------

// File: rtl/uart_tx_scheduler_pkg.sv
// Shared definitions for the UART TX scheduler: FSM states, frame length
// and the ASCII constants used to build the "<tag><dddd>\r\n" frame.
package uart_tx_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_SEND    = 2'd2
  } state_e;

  localparam int unsigned FRAME_LEN = 7;

  localparam logic [7:0] ASCII_ZERO     = 8'h30;
  localparam logic [7:0] ASCII_TAG_BASE = 8'h41;
  localparam logic [7:0] ASCII_CR       = 8'h0D;
  localparam logic [7:0] ASCII_LF       = 8'h0A;

endpackage

// File: rtl/uart_tx_scheduler_bin10_to_ascii4.sv
// Combinational 10-bit binary to four ASCII decimal digits (0000..1023).
module bin10_to_ascii4
  import uart_tx_scheduler_pkg::*;
(
  input  logic [9:0] bin,
  output logic [7:0] thousands,
  output logic [7:0] hundreds,
  output logic [7:0] tens,
  output logic [7:0] units
);

  // Each digit is a quotient/remainder by a power of ten, offset into ASCII.
  always_comb begin
    thousands = ASCII_ZERO + 8'(bin / 10'd1000);
    hundreds  = ASCII_ZERO + 8'((bin / 10'd100) % 10'd10);
    tens      = ASCII_ZERO + 8'((bin / 10'd10) % 10'd10);
    units     = ASCII_ZERO + 8'(bin % 10'd10);
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler sharing one UART TX FIFO push port among NUM_REQ
// requesters. Each granted 10-bit value is sent as a 7-byte ASCII frame.
module uart_tx_scheduler
  import uart_tx_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 10,
  localparam int unsigned GW     = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      tx_full,
  output logic                      tx_push,
  output logic [7:0]                tx_push_data,
  output logic                      busy,
  output logic [GW-1:0]             grant_id,
  output logic                      frame_done
);

  state_e                       state_q, state_d;
  logic [GW-1:0]                grant_q, grant_d;
  logic [GW-1:0]                last_q, last_d;
  logic [DATA_W-1:0]            data_q, data_d;
  logic [2:0]                   byte_idx_q, byte_idx_d;
  logic [FRAME_LEN-1:0][7:0]    frame_q, frame_d;
  logic                         push_q, push_d;
  logic [7:0]                   push_data_q, push_data_d;
  logic                         done_q, done_d;

  logic                         pick_found;
  logic [GW-1:0]                pick_idx;
  logic [GW-1:0]                cand_idx;
  int unsigned                  cand;

  logic [7:0]                   dig_th, dig_hu, dig_te, dig_un;
  logic [FRAME_LEN-1:0][7:0]    frame_build;
  logic                         can_push;

  bin10_to_ascii4 u_bin10_to_ascii4 (
    .bin       (data_q),
    .thousands (dig_th),
    .hundreds  (dig_hu),
    .tens      (dig_te),
    .units     (dig_un)
  );

  // Round-robin pick: first valid requester after the last granted one.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand     = (32'(last_q) + 1 + k) % NUM_REQ;
      cand_idx = GW'(cand);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Frame image of the captured value; byte 0 sits in the low byte.
  always_comb begin
    frame_build = {ASCII_LF, ASCII_CR, dig_un, dig_te, dig_hu, dig_th,
                   ASCII_TAG_BASE + 8'(grant_q)};
  end

  // FSM next state, frame buffer and push scheduling.
  // Byte 0 is pushed straight from the freshly built frame during CAPTURE so
  // the first push lands two cycles after the grant; byte_idx counts bytes
  // already issued, so reaching FRAME_LEN marks the frame complete.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    data_d      = data_q;
    byte_idx_d  = byte_idx_q;
    frame_d     = frame_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    done_d      = 1'b0;
    can_push    = !tx_full && !push_q;

    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_d    = pick_idx;
          data_d     = req_data[32'(pick_idx)*DATA_W +: DATA_W];
          byte_idx_d = '0;
          state_d    = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        frame_d = frame_build;
        state_d = ST_SEND;
        if (can_push) begin
          push_d      = 1'b1;
          push_data_d = frame_build[0];
          byte_idx_d  = 3'd1;
        end
      end
      ST_SEND: begin
        if (byte_idx_q == 3'(FRAME_LEN)) begin
          last_d  = grant_q;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (can_push) begin
          push_d      = 1'b1;
          push_data_d = frame_q[byte_idx_q];
          byte_idx_d  = byte_idx_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      last_q      <= GW'(NUM_REQ - 1);
      data_q      <= '0;
      byte_idx_q  <= '0;
      frame_q     <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      data_q      <= data_d;
      byte_idx_q  <= byte_idx_d;
      frame_q     <= frame_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      done_q      <= done_d;
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    req_ready    = (state_q == ST_CAPTURE) ? (NUM_REQ'(1) << grant_q) : '0;
    busy         = (state_q != ST_IDLE);
    grant_id     = grant_q;
    tx_push      = push_q;
    tx_push_data = push_data_q;
    frame_done   = done_q;
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed self-checking bench for uart_tx_scheduler (NUM_REQ=4).
module tb_uart_tx_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [39:0] req_data;
  logic [3:0]  req_ready;
  logic        tx_full;
  logic        tx_push;
  logic [7:0]  tx_push_data;
  logic        busy;
  logic [1:0]  grant_id;
  logic        frame_done;

  int tests;
  int fails;

  uart_tx_scheduler #(.NUM_REQ(4), .DATA_W(10)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .tx_full      (tx_full),
    .tx_push      (tx_push),
    .tx_push_data (tx_push_data),
    .busy         (busy),
    .grant_id     (grant_id),
    .frame_done   (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0][7:0] fr(input logic [7:0] t, input logic [7:0] d3,
                                         input logic [7:0] d2, input logic [7:0] d1,
                                         input logic [7:0] d0);
    fr = {8'h0A, 8'h0D, d0, d1, d2, d3, t};
  endfunction

  task automatic check_reset(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'h0);
    check({tag, "_push"}, 32'(tx_push), 32'h0);
    check({tag, "_pdata"}, 32'(tx_push_data), 32'h0);
    check({tag, "_busy"}, 32'(busy), 32'h0);
    check({tag, "_grant"}, 32'(grant_id), 32'h0);
    check({tag, "_done"}, 32'(frame_done), 32'h0);
  endtask

  task automatic check_grant(input int g);
    logic [3:0] onehot;
    onehot = 4'b0001 << g;
    check("ready_onehot", 32'(req_ready), 32'(onehot));
    check("grant_id", 32'(grant_id), 32'(g));
    check("busy_capture", 32'(busy), 32'h1);
    check("push_capture", 32'(tx_push), 32'h0);
    check("done_capture", 32'(frame_done), 32'h0);
  endtask

  // Push of byte j on one cycle, gap (or completion) on the next.
  task automatic send_bytes(input logic [6:0][7:0] b, input int from, input int to);
    for (int j = from; j <= to; j++) begin
      step();
      check($sformatf("push%0d", j), 32'(tx_push), 32'h1);
      check($sformatf("byte%0d", j), 32'(tx_push_data), 32'(b[j]));
      check($sformatf("ready_low%0d", j), 32'(req_ready), 32'h0);
      step();
      check($sformatf("gap%0d", j), 32'(tx_push), 32'h0);
      if (j == 6) begin
        check("frame_done", 32'(frame_done), 32'h1);
        check("idle_after", 32'(busy), 32'h0);
      end else begin
        check($sformatf("no_done%0d", j), 32'(frame_done), 32'h0);
        check($sformatf("busy%0d", j), 32'(busy), 32'h1);
      end
    end
  endtask

  logic [6:0][7:0] f_seq [5];
  int              g_seq [5];

  initial begin
    tests     = 0;
    fails     = 0;
    rst       = 1'b0;
    req_valid = '0;
    req_data  = '0;
    tx_full   = 1'b0;

    // Reset state
    repeat (3) step();
    check_reset("rst");
    rst = 1'b1;
    step();
    check("idle_busy", 32'(busy), 32'h0);

    // Single request from requester 2, value 345
    req_data[29:20] = 10'd345;
    req_valid       = 4'b0100;
    step();
    check_grant(2);
    req_valid = '0;
    send_bytes(fr(8'h43, 8'h30, 8'h33, 8'h34, 8'h35), 0, 6);

    // Edge values from requester 0
    req_data[9:0] = 10'd0;
    req_valid     = 4'b0001;
    step();
    check_grant(0);
    req_valid = '0;
    send_bytes(fr(8'h41, 8'h30, 8'h30, 8'h30, 8'h30), 0, 6);
    req_data[9:0] = 10'd1023;
    req_valid     = 4'b0001;
    step();
    check_grant(0);
    req_valid = '0;
    send_bytes(fr(8'h41, 8'h31, 8'h30, 8'h32, 8'h33), 0, 6);

    // All four held valid from reset: A, B, C, D, A
    rst = 1'b0;
    step();
    check_reset("rst2");
    rst       = 1'b1;
    req_data  = {10'd1000, 10'd333, 10'd22, 10'd1};
    req_valid = 4'b1111;
    f_seq[0]  = fr(8'h41, 8'h30, 8'h30, 8'h30, 8'h31);
    f_seq[1]  = fr(8'h42, 8'h30, 8'h30, 8'h32, 8'h32);
    f_seq[2]  = fr(8'h43, 8'h30, 8'h33, 8'h33, 8'h33);
    f_seq[3]  = fr(8'h44, 8'h31, 8'h30, 8'h30, 8'h30);
    f_seq[4]  = f_seq[0];
    g_seq     = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      step();
      check_grant(g_seq[i]);
      send_bytes(f_seq[i], 0, 6);
    end
    req_valid = '0;

    // Backpressure: 20-cycle stall after byte 2, value 512 from requester 0
    req_data[9:0] = 10'd512;
    req_valid     = 4'b0001;
    step();
    check_grant(0);
    req_valid = '0;
    send_bytes(fr(8'h41, 8'h30, 8'h35, 8'h31, 8'h32), 0, 1);
    step();
    check("bp_push2", 32'(tx_push), 32'h1);
    check("bp_byte2", 32'(tx_push_data), 32'h35);
    tx_full = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("stall_push%0d", i), 32'(tx_push), 32'h0);
      check($sformatf("stall_busy%0d", i), 32'(busy), 32'h1);
    end
    tx_full = 1'b0;
    send_bytes(fr(8'h41, 8'h30, 8'h35, 8'h31, 8'h32), 3, 6);

    // Withdrawal: requester 1 drops while requester 0 is served
    rst = 1'b0;
    step();
    rst           = 1'b1;
    req_data[9:0] = 10'd7;
    req_data[19:10] = 10'd5;
    req_valid     = 4'b0011;
    step();
    check_grant(0);
    req_valid = '0;
    send_bytes(fr(8'h41, 8'h30, 8'h30, 8'h30, 8'h37), 0, 6);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("wd_busy%0d", i), 32'(busy), 32'h0);
      check($sformatf("wd_ready%0d", i), 32'(req_ready), 32'h0);
    end

    // Mid-frame reset at byte 3 of a frame from requester 3
    req_data[39:30] = 10'd9;
    req_valid       = 4'b1000;
    step();
    check_grant(3);
    req_valid = '0;
    send_bytes(fr(8'h44, 8'h30, 8'h30, 8'h30, 8'h39), 0, 2);
    step();
    check("mid_push3", 32'(tx_push), 32'h1);
    check("mid_byte3", 32'(tx_push_data), 32'h30);
    rst = 1'b0;
    step();
    check_reset("mid");
    rst       = 1'b1;
    req_valid = 4'b1001;
    step();
    check_grant(0);
    req_valid = '0;
    send_bytes(fr(8'h41, 8'h30, 8'h30, 8'h30, 8'h37), 0, 6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
